nios_system_sysid_checker: RTL

//  Avalon-MM read master that sequences the system-ID slave: reads ID word (addr 0) and

---
 rtl/nios_system_sysid_pkg.sv | 16 +
 rtl/nios_system_sysid_checker_if.sv | 23 ++
 rtl/nios_system_sysid_chk_timer.sv | 27 ++
 rtl/nios_system_sysid_checker.sv | 126 ++++++++++++
 4 files changed

// File: rtl/nios_system_sysid_pkg.sv
// Shared definitions for the system-ID checker: FSM state encoding and sysid slave word addresses.
package nios_system_sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ID,
        ST_RD_TS,
        ST_CMP,
        ST_DONE,
        ST_WAIT
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

// File: rtl/nios_system_sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the sysid slave.
interface nios_system_sysid_checker_if;

    logic        m_address;
    logic        m_read;
    logic        m_waitrequest;
    logic [31:0] m_readdata;

    modport master (
        output m_address,
        output m_read,
        input  m_waitrequest,
        input  m_readdata
    );

    modport slave (
        input  m_address,
        input  m_read,
        output m_waitrequest,
        output m_readdata
    );

endinterface

// File: rtl/nios_system_sysid_chk_timer.sv
// Saturating up-counter with synchronous clear; expire flags count == limit.
module nios_system_sysid_chk_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

    assign expire = (count == limit);

endmodule

// File: rtl/nios_system_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words and checks them against
// the expected image values, with optional auto-start, periodic re-check and read timeout.
module nios_system_sysid_checker
    import nios_system_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1581583582,
    parameter bit          AUTO_START     = 1'b1,
    parameter int unsigned PERIOD         = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    nios_system_sysid_checker_if.master        avm,
    output logic                               busy,
    output logic                               done,
    output logic                               id_match,
    output logic                               ts_match,
    output logic                               timeout,
    output logic [31:0]                        sys_id,
    output logic [31:0]                        sys_ts
);

    localparam int unsigned CNT_MAX = (PERIOD > TIMEOUT_CYCLES) ? PERIOD : TIMEOUT_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    state_t          state;
    logic            auto_pending;
    logic            tmr_hold;
    logic            tmr_expire;
    logic [CW-1:0]   tmr_limit;

    // One timer serves both the WAIT period and the read timeout: it runs only while the FSM
    // stays in a counting state and is cleared on every other cycle, so each entry starts at 0.
    // The timeout limit is one less than TIMEOUT_CYCLES because expiry is checked on the stall
    // cycle that would make the count reach TIMEOUT_CYCLES.
    always_comb begin
        tmr_limit = (state == ST_WAIT) ? CW'(PERIOD) : CW'(TIMEOUT_CYCLES - 1);
        tmr_hold  = 1'b0;
        case (state)
            ST_RD_ID, ST_RD_TS: tmr_hold = avm.m_waitrequest && !tmr_expire;
            ST_WAIT:            tmr_hold = !start && !tmr_expire;
            default:            tmr_hold = 1'b0;
        endcase
    end

    nios_system_sysid_chk_timer #(
        .WIDTH (CW)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clr    (!tmr_hold),
        .en     (tmr_hold),
        .limit  (tmr_limit),
        .expire (tmr_expire)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            auto_pending  <= AUTO_START;
            avm.m_read    <= 1'b0;
            avm.m_address <= SYSID_ADDR_ID;
            busy          <= 1'b0;
            done          <= 1'b0;
            id_match      <= 1'b0;
            ts_match      <= 1'b0;
            timeout       <= 1'b0;
            sys_id        <= '0;
            sys_ts        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_WAIT: begin
                    if (start || (state == ST_IDLE && auto_pending) ||
                        (state == ST_WAIT && tmr_expire)) begin
                        auto_pending  <= 1'b0;
                        state         <= ST_RD_ID;
                        avm.m_read    <= 1'b1;
                        avm.m_address <= SYSID_ADDR_ID;
                        busy          <= 1'b1;
                        id_match      <= 1'b0;
                        ts_match      <= 1'b0;
                        timeout       <= 1'b0;
                    end
                end
                ST_RD_ID, ST_RD_TS: begin
                    if (!avm.m_waitrequest) begin
                        if (state == ST_RD_ID) begin
                            sys_id        <= avm.m_readdata;
                            avm.m_address <= SYSID_ADDR_TS;
                            state         <= ST_RD_TS;
                        end else begin
                            sys_ts        <= avm.m_readdata;
                            avm.m_read    <= 1'b0;
                            avm.m_address <= SYSID_ADDR_ID;
                            state         <= ST_CMP;
                        end
                    end else if (tmr_expire) begin
                        avm.m_read    <= 1'b0;
                        avm.m_address <= SYSID_ADDR_ID;
                        timeout       <= 1'b1;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        state         <= ST_DONE;
                    end
                end
                ST_CMP: begin
                    id_match <= (sys_id == EXPECTED_ID);
                    ts_match <= (sys_ts == EXPECTED_TS);
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    state <= (PERIOD > 0) ? ST_WAIT : ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
